// File: rtl/rv_enc_pkg.sv
// Shared opcode constants, error codes and immediate ranges for the RV instruction encoder.
package rv_enc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_ALIGN  = 2'd3
    } err_code_e;

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;

endpackage

// File: rtl/enc_fifo.sv
// Output FIFO for encoded words; head entry is presented directly from storage (no extra latency).
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign do_push   = push && !full;
    assign do_pop    = pop && out_valid;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes I/B/U-type RISC-V requests into 32-bit words with range checks, error reporting
// and a buffered, address-tagged output stream.
module inst_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);

    logic signed [31:0] imm_s;
    logic [31:0]        enc_word;
    err_code_e          enc_err;
    logic               accept, push, reject, fifo_full;
    logic [63:0]        fifo_out;

    logic [31:0] addr_q, addr_d;
    logic        err_valid_q, err_valid_d;
    err_code_e   err_code_q, err_code_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    assign imm_s = $signed(in_imm);

    // Error priority: opcode, then range, then alignment.
    always_comb begin
        enc_word = '0;
        enc_err  = ERR_NONE;
        case (in_opcode)
            OP_LOAD, OP_IMM: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                if (imm_s < I_MIN || imm_s > I_MAX) enc_err = ERR_RANGE;
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                if (imm_s < B_MIN || imm_s > B_MAX) enc_err = ERR_RANGE;
                else if (in_imm[0])                 enc_err = ERR_ALIGN;
            end
            OP_LUI: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                if (in_imm[11:0] != '0) enc_err = ERR_ALIGN;
            end
            default: enc_err = ERR_OPCODE;
        endcase
    end

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (enc_err == ERR_NONE);
    assign reject   = accept && (enc_err != ERR_NONE);

    always_comb begin
        addr_d      = push ? addr_q + 32'd4 : addr_q;
        err_valid_d = reject;
        err_code_d  = reject ? enc_err : ERR_NONE;
        err_cnt_d   = (reject && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= BASE_ADDR;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({enc_word, addr_q}),
        .full      (fifo_full),
        .pop       (out_valid && out_ready),
        .out_valid (out_valid),
        .out_data  (fifo_out)
    );

    assign out_inst  = fifo_out[63:32];
    assign out_addr  = fifo_out[31:0];
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, error codes, backpressure and reset behaviour.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst, out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_encoder #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    // Drive one request at the falling edge, then sample 1 ns after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        @(negedge clk);
        set_req(op, rd, rs1, rs2, f3, imm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b0;

        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // ADDI x1, x0, -1
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_inst", out_inst, 32'hFFF0_0093);
        chk("addi_addr", out_addr, 32'd0);
        chk("addi_no_err", {31'd0, err_valid}, 32'd0);

        // LUI x5, 0x12345
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        chk("lui_inst", out_inst, 32'h1234_52B7);
        chk("lui_addr", out_addr, 32'd4);

        // LUI with low bits set -> misaligned
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
        chk("lui_mis_err_valid", {31'd0, err_valid}, 32'd1);
        chk("lui_mis_err_code", {30'd0, err_code}, 32'd3);
        chk("lui_mis_no_out", {31'd0, out_valid}, 32'd0);
        chk("lui_mis_cnt", {24'd0, err_cnt}, 32'd1);

        // BEQ x1, x2, -4
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        chk("beq_inst", out_inst, 32'hFE20_8EE3);
        chk("beq_addr", out_addr, 32'd8);
        chk("beq_err_pulse_gone", {31'd0, err_valid}, 32'd0);

        // BEQ out of range
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096);
        chk("beq_rng_code", {30'd0, err_code}, 32'd2);
        chk("beq_rng_cnt", {24'd0, err_cnt}, 32'd2);
        chk("beq_rng_no_out", {31'd0, out_valid}, 32'd0);

        // R-type opcode unsupported
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0);
        chk("badop_code", {30'd0, err_code}, 32'd1);
        chk("badop_cnt", {24'd0, err_cnt}, 32'd3);

        // LW x3, 2047(x2), rs2 ignored; address continues from 8
        send(7'b0000011, 5'd3, 5'd2, 5'd31, 3'd2, 32'd2047);
        chk("lw_inst", out_inst, 32'h7FF1_2183);
        chk("lw_addr", out_addr, 32'd12);

        // ADDI imm=2048 out of range
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        chk("addi_rng_code", {30'd0, err_code}, 32'd2);

        // Branch odd offset, in range -> misaligned
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd6 + 32'd1);
        chk("b_odd_code", {30'd0, err_code}, 32'd3);
        chk("b_odd_cnt", {24'd0, err_cnt}, 32'd5);

        // BNE x0, x0, -4096 (lower bound legal)
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd1, 32'hFFFF_F000);
        chk("bne_min_inst", out_inst, 32'h8000_1063);
        chk("bne_min_addr", out_addr, 32'd16);

        // Backpressure from a clean reset so addresses restart at 0
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd5);
        chk("bp_rdy_after_1", {31'd0, in_ready}, 32'd1);
        send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd6);
        chk("bp_rdy_after_2", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        set_req(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'd7);
        tick();
        chk("bp_blocked_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_inst", out_inst, 32'h0050_0113);
        chk("bp_hold_addr", out_addr, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        chk("bp_second_inst", out_inst, 32'h0060_0193);
        chk("bp_second_addr", out_addr, 32'd4);
        chk("bp_rdy_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third_inst", out_inst, 32'h0070_0213);
        chk("bp_third_addr", out_addr, 32'd8);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two entries buffered
        @(negedge clk);
        out_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_inst", out_inst, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_no_out", {31'd0, out_valid}, 32'd0);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        chk("post_rst_inst", out_inst, 32'hFFF0_0093);
        chk("post_rst_addr", out_addr, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
